// File: rtl/morse_receiver.sv
// morse_receiver: decodes on-off-keyed Morse from one asynchronous pin into
// per-letter element codes. Timing is unit based (1 unit = TICK_RATE cycles).
//
// Ports:
//   CLK          system clock
//   RST_N        asynchronous active-low reset
//   PIN          raw asynchronous Morse line, high = mark
//   sym_valid    one-cycle pulse, a letter is complete
//   sym_code     element bits, right-aligned, first element at MSB of used field (1 = dash)
//   sym_len      number of elements, 1..6
//   sym_err      qualified by sym_valid, the letter had more than 6 elements
//   word_gap     one-cycle pulse, word gap seen after a letter
//   mark_active  high while the FSM is in MARK
module morse_receiver #(
  parameter int unsigned TICK_RATE    = 5_000_000,
  parameter int unsigned DASH_UNITS   = 2,
  parameter int unsigned LETTER_UNITS = 2,
  parameter int unsigned WORD_UNITS   = 5
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PIN,
  output logic       sym_valid,
  output logic [5:0] sym_code,
  output logic [2:0] sym_len,
  output logic       sym_err,
  output logic       word_gap,
  output logic       mark_active
);

  localparam int unsigned DASH_CYC   = DASH_UNITS * TICK_RATE;
  localparam int unsigned LETTER_CYC = LETTER_UNITS * TICK_RATE;
  localparam int unsigned WORD_CYC   = WORD_UNITS * TICK_RATE;
  localparam int unsigned CNT_W      = $clog2(WORD_CYC + 1);

  // cnt lags the run length by one cycle (cleared on the edge after the level
  // change), so every threshold compares against limit-1.
  localparam logic [CNT_W-1:0] DASH_LIM   = CNT_W'(DASH_CYC - 1);
  localparam logic [CNT_W-1:0] LETTER_LIM = CNT_W'(LETTER_CYC - 1);
  localparam logic [CNT_W-1:0] WORD_LIM   = CNT_W'(WORD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {IDLE, MARK, GAP, LETTER} state_t;

  state_t           state, state_nxt;
  logic             sync_q, lvl;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             dash_c;

  logic [5:0] acc_code, acc_code_nxt;
  logic [2:0] acc_len, acc_len_nxt;
  logic       acc_err, acc_err_nxt;

  logic       sym_valid_nxt, sym_err_nxt, word_gap_nxt, mark_active_nxt;
  logic [5:0] sym_code_nxt;
  logic [2:0] sym_len_nxt;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= 1'b0;
      lvl    <= 1'b0;
    end else begin
      sync_q <= PIN;
      lvl    <= sync_q;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; in GAP the letter threshold wins over a rising level.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (lvl) state_nxt = MARK;
      MARK:    if (!lvl) state_nxt = GAP;
      GAP: begin
        if (cnt == LETTER_LIM) state_nxt = LETTER;
        else if (lvl)          state_nxt = MARK;
      end
      LETTER: begin
        if (lvl)                  state_nxt = MARK;
        else if (cnt == WORD_LIM) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    acc_code_nxt    = acc_code;
    acc_len_nxt     = acc_len;
    acc_err_nxt     = acc_err;
    sym_valid_nxt   = 1'b0;
    sym_code_nxt    = sym_code;
    sym_len_nxt     = sym_len;
    sym_err_nxt     = sym_err;
    word_gap_nxt    = 1'b0;
    mark_active_nxt = (state_nxt == MARK);
    dash_c          = (cnt >= DASH_LIM);
    // The low run keeps counting across GAP->LETTER so the word gap is
    // measured from the falling edge.
    cnt_clr         = (state_nxt != state) && !(state == GAP && state_nxt == LETTER);

    // Classify the completed mark; elements past the sixth are dropped.
    if (state == MARK && !lvl) begin
      if (acc_len < 3'd6) begin
        acc_code_nxt = {acc_code[4:0], dash_c};
        acc_len_nxt  = acc_len + 3'd1;
      end else begin
        acc_err_nxt = 1'b1;
      end
    end

    if (state == GAP && state_nxt == LETTER) begin
      sym_valid_nxt = 1'b1;
      sym_code_nxt  = acc_code;
      sym_len_nxt   = acc_len;
      sym_err_nxt   = acc_err;
      acc_code_nxt  = 6'd0;
      acc_len_nxt   = 3'd0;
      acc_err_nxt   = 1'b0;
    end

    if (state == LETTER && state_nxt == IDLE) word_gap_nxt = 1'b1;
  end

  // Duration counter, saturating, plus accumulator and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt         <= '0;
      acc_code    <= 6'd0;
      acc_len     <= 3'd0;
      acc_err     <= 1'b0;
      sym_valid   <= 1'b0;
      sym_code    <= 6'd0;
      sym_len     <= 3'd0;
      sym_err     <= 1'b0;
      word_gap    <= 1'b0;
      mark_active <= 1'b0;
    end else begin
      if (cnt_clr)              cnt <= '0;
      else if (cnt != CNT_MAX)  cnt <= cnt + CNT_W'(1);
      acc_code    <= acc_code_nxt;
      acc_len     <= acc_len_nxt;
      acc_err     <= acc_err_nxt;
      sym_valid   <= sym_valid_nxt;
      sym_code    <= sym_code_nxt;
      sym_len     <= sym_len_nxt;
      sym_err     <= sym_err_nxt;
      word_gap    <= word_gap_nxt;
      mark_active <= mark_active_nxt;
    end
  end

endmodule

// File: tb/tb_morse_receiver.sv
// Testbench for morse_receiver at TICK_RATE=4: directed letters are driven on
// PIN, expected letters/word gaps are queued, and a monitor compares them.
module tb_morse_receiver;

  localparam int TICK   = 4;
  localparam int DOT    = TICK;
  localparam int DASH   = 3 * TICK;
  // PIN fall -> word_gap observed: 2 sync cycles + 5 units + 1 output register.
  localparam int WG_LAT = 2 + 5 * TICK + 1;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       PIN = 1'b0;
  logic       sym_valid;
  logic [5:0] sym_code;
  logic [2:0] sym_len;
  logic       sym_err;
  logic       word_gap;
  logic       mark_active;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit         is_word;
    logic [5:0] code;
    logic [2:0] len;
    logic       err;
    int         at;
  } exp_t;

  exp_t exp_q[$];

  morse_receiver #(.TICK_RATE(TICK)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .PIN(PIN),
    .sym_valid(sym_valid),
    .sym_code(sym_code),
    .sym_len(sym_len),
    .sym_err(sym_err),
    .word_gap(word_gap),
    .mark_active(mark_active)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void push_letter(input logic [5:0] code, input logic [2:0] len, input logic err);
    exp_t e;
    e.is_word = 1'b0; e.code = code; e.len = len; e.err = err; e.at = 0;
    exp_q.push_back(e);
  endfunction

  function automatic void push_word(input int at);
    exp_t e;
    e.is_word = 1'b1; e.code = 6'd0; e.len = 3'd0; e.err = 1'b0; e.at = at;
    exp_q.push_back(e);
  endfunction

  // Hold PIN at v for n sampling edges (changes on the falling clock edge).
  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      PIN = v;
    end
  endtask

  // Send n elements (els[n-1] first, 1 = dash), then a low tail.
  // The next negedge is the PIN fall, at cycle cyc+1.
  task automatic send(input int n, input logic [7:0] els, input int tail, input bit exp_word);
    for (int i = n - 1; i >= 0; i--) begin
      drive(1'b1, els[i] ? DASH : DOT);
      if (i > 0) drive(1'b0, DOT);
    end
    if (exp_word) push_word(cyc + 1 + WG_LAT);
    drive(1'b0, tail);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".sym_valid"},   32'(sym_valid),   32'd0);
    chk({tag, ".sym_code"},    32'(sym_code),    32'd0);
    chk({tag, ".sym_len"},     32'(sym_len),     32'd0);
    chk({tag, ".sym_err"},     32'(sym_err),     32'd0);
    chk({tag, ".word_gap"},    32'(word_gap),    32'd0);
    chk({tag, ".mark_active"}, 32'(mark_active), 32'd0);
  endtask

  // Monitor: pop and compare whenever the DUT presents a pulse.
  always @(negedge CLK) begin
    if (RST_N && (sym_valid || word_gap)) begin
      exp_t e;
      chk("pulse_exclusive", 32'(sym_valid && word_gap), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: sym_valid=%0d word_gap=%0d, expected none (cycle %0d)",
                 sym_valid, word_gap, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", 32'(word_gap), 32'(e.is_word));
        if (e.is_word) begin
          chk("word_gap_cycle", 32'(cyc), 32'(e.at));
        end else begin
          chk("sym_code", 32'(sym_code), 32'(e.code));
          chk("sym_len",  32'(sym_len),  32'(e.len));
          chk("sym_err",  32'(sym_err),  32'(e.err));
        end
      end
    end
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge CLK);
    chk_all_zero("reset");
    RST_N = 1'b1;
    drive(1'b0, 4);

    // "S" with only a letter gap: no word_gap.
    push_letter(6'b000000, 3'd3, 1'b0);
    send(3, 8'b000, 12, 1'b0);

    // "O" then a word gap timed from the final falling edge.
    push_letter(6'b000111, 3'd3, 1'b0);
    send(3, 8'b111, 28, 1'b1);

    // Two dashes, then a 1-cycle reset pulse aborts the letter.
    drive(1'b1, 6);
    chk("mark_active", 32'(mark_active), 32'd1);
    drive(1'b1, 6);
    drive(1'b0, DOT);
    drive(1'b1, DASH);
    drive(1'b0, 2);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk_all_zero("abort");
    @(negedge CLK);
    RST_N = 1'b1;
    drive(1'b0, 30);

    // "T" after the abort.
    push_letter(6'b000001, 3'd1, 1'b0);
    send(1, 8'b1, 28, 1'b1);

    // Dash threshold sweep: 7 cycles is a dot, 8 cycles is a dash.
    push_letter(6'b000000, 3'd1, 1'b0);
    drive(1'b1, 7);
    push_word(cyc + 1 + WG_LAT);
    drive(1'b0, 28);
    push_letter(6'b000001, 3'd1, 1'b0);
    drive(1'b1, 8);
    push_word(cyc + 1 + WG_LAT);
    drive(1'b0, 28);

    // Seven dots overflow, then "E" is clean.
    push_letter(6'b000000, 3'd6, 1'b1);
    send(7, 8'b0000000, 28, 1'b1);
    push_letter(6'b000000, 3'd1, 1'b0);
    send(1, 8'b0, 28, 1'b1);

    // Blinker SOS loopback: letter gaps of 3 units, trailing word gap.
    push_letter(6'b000000, 3'd3, 1'b0);
    send(3, 8'b000, 3 * TICK, 1'b0);
    push_letter(6'b000111, 3'd3, 1'b0);
    send(3, 8'b111, 3 * TICK, 1'b0);
    push_letter(6'b000000, 3'd3, 1'b0);
    send(3, 8'b000, 7 * TICK, 1'b1);

    drive(1'b0, 40);
    chk("pending_expected", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
